// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if
//   Bundles the signals between the two masters, the arbiter and the SDRAM
//   controller request/acknowledge port.
//   Master side : p0_* (video fetch) and p1_* (CPU) request/response signals.
//   Controller  : sdram_init_done, ctl_wr_req/ctl_rd_req, ctl_addr, ctl_wdata,
//                 ctl_wr_ack/ctl_rd_ack, ctl_rdata.
//   Debug       : grant_port, arb_state.
//   Modports:
//     slave  - the arbiter's view (takes requests and acks, drives the rest)
//     master - the environment's view (masters plus controller)
interface sdram_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic              p0_req;
  logic              p1_req;
  logic              p0_rw_n;
  logic              p1_rw_n;
  logic [ADDR_W-1:0] p0_addr;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic [DATA_W-1:0] p1_wdata;
  logic              p0_done;
  logic              p1_done;
  logic              p0_err;
  logic              p1_err;
  logic [DATA_W-1:0] p0_rdata;
  logic [DATA_W-1:0] p1_rdata;
  logic              sdram_init_done;
  logic              ctl_wr_req;
  logic              ctl_rd_req;
  logic [ADDR_W-1:0] ctl_addr;
  logic [DATA_W-1:0] ctl_wdata;
  logic              ctl_wr_ack;
  logic              ctl_rd_ack;
  logic [DATA_W-1:0] ctl_rdata;
  logic              grant_port;
  logic [1:0]        arb_state;

  modport slave (
    input  p0_req, p1_req, p0_rw_n, p1_rw_n, p0_addr, p1_addr,
    input  p0_wdata, p1_wdata,
    output p0_done, p1_done, p0_err, p1_err, p0_rdata, p1_rdata,
    input  sdram_init_done,
    output ctl_wr_req, ctl_rd_req, ctl_addr, ctl_wdata,
    input  ctl_wr_ack, ctl_rd_ack, ctl_rdata,
    output grant_port, arb_state
  );

  modport master (
    output p0_req, p1_req, p0_rw_n, p1_rw_n, p0_addr, p1_addr,
    output p0_wdata, p1_wdata,
    input  p0_done, p1_done, p0_err, p1_err, p0_rdata, p1_rdata,
    output sdram_init_done,
    input  ctl_wr_req, ctl_rd_req, ctl_addr, ctl_wdata,
    output ctl_wr_ack, ctl_rd_ack, ctl_rdata,
    input  grant_port, arb_state
  );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Two-port round-robin arbiter in front of an SDRAM controller's level
//   request / pulse acknowledge interface. One command is latched at grant,
//   held on ctl_wr_req/ctl_rd_req until its matching ack (or a watchdog
//   abort), then completion is reported to the owning port as a one-cycle
//   done (or err) pulse, with read data captured on read acks.
//   Ports:
//     clk_100m - system clock
//     rst_n    - asynchronous active-low reset
//     bus      - sdram_arbiter_if.slave (master ports, controller port, debug)
//   Parameters: ADDR_W / DATA_W widths, TIMEOUT watchdog limit in S_ISSUE
//   cycles (>= 2).
module sdram_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic           clk_100m,
  input  logic           rst_n,
  sdram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic                   last_grant_q, last_grant_d;
  logic                   grant_port_q, grant_port_d;
  logic                   rw_n_q, rw_n_d;
  logic [ADDR_W-1:0]      ctl_addr_q, ctl_addr_d;
  logic [DATA_W-1:0]      ctl_wdata_q, ctl_wdata_d;
  logic                   ctl_wr_req_q, ctl_wr_req_d;
  logic                   ctl_rd_req_q, ctl_rd_req_d;
  logic [WD_W-1:0]        wdog_q, wdog_d;
  logic [1:0]             done_q, done_d;
  logic [1:0]             err_q, err_d;
  logic [1:0][DATA_W-1:0] rdata_q, rdata_d;

  logic [1:0] req_vec;
  logic       grant_sel;
  logic       ack_match;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_port_d = grant_port_q;
    rw_n_d       = rw_n_q;
    ctl_addr_d   = ctl_addr_q;
    ctl_wdata_d  = ctl_wdata_q;
    ctl_wr_req_d = ctl_wr_req_q;
    ctl_rd_req_d = ctl_rd_req_q;
    wdog_d       = wdog_q;
    done_d       = '0;
    err_d        = '0;
    rdata_d      = rdata_q;

    req_vec   = {bus.p1_req, bus.p0_req};
    // Under contention the port that did not own the last command wins;
    // otherwise the lone requester (bit 1 set means port 1).
    grant_sel = (req_vec == 2'b11) ? ~last_grant_q : req_vec[1];
    // Only the ack type matching the latched command counts.
    ack_match = rw_n_q ? bus.ctl_wr_ack : bus.ctl_rd_ack;

    case (state_q)
      S_IDLE: begin
        if (bus.sdram_init_done && (req_vec != 2'b00)) begin
          grant_port_d = grant_sel;
          rw_n_d       = grant_sel ? bus.p1_rw_n  : bus.p0_rw_n;
          ctl_addr_d   = grant_sel ? bus.p1_addr  : bus.p0_addr;
          ctl_wdata_d  = grant_sel ? bus.p1_wdata : bus.p0_wdata;
          ctl_wr_req_d = grant_sel ? bus.p1_rw_n  : bus.p0_rw_n;
          ctl_rd_req_d = grant_sel ? ~bus.p1_rw_n : ~bus.p0_rw_n;
          wdog_d       = '0;
          state_d      = S_ISSUE;
        end
      end

      S_ISSUE: begin
        wdog_d = wdog_q + 1'b1;
        // Ack is tested first so it wins over a same-cycle timeout.
        if (ack_match) begin
          ctl_wr_req_d           = 1'b0;
          ctl_rd_req_d           = 1'b0;
          done_d[grant_port_q]   = 1'b1;
          last_grant_d           = grant_port_q;
          state_d                = S_RECOVER;
          if (!rw_n_q) begin
            rdata_d[grant_port_q] = bus.ctl_rdata;
          end
        end else if (wdog_q == WD_LAST) begin
          ctl_wr_req_d         = 1'b0;
          ctl_rd_req_d         = 1'b0;
          err_d[grant_port_q]  = 1'b1;
          last_grant_d         = grant_port_q;
          state_d              = S_RECOVER;
        end
      end

      // One dead cycle keeps the controller request low between commands
      // and lets the finished master drop its req before arbitration.
      S_RECOVER: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_port_q <= 1'b0;
      rw_n_q       <= 1'b0;
      ctl_addr_q   <= '0;
      ctl_wdata_q  <= '0;
      ctl_wr_req_q <= 1'b0;
      ctl_rd_req_q <= 1'b0;
      wdog_q       <= '0;
      done_q       <= '0;
      err_q        <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_port_q <= grant_port_d;
      rw_n_q       <= rw_n_d;
      ctl_addr_q   <= ctl_addr_d;
      ctl_wdata_q  <= ctl_wdata_d;
      ctl_wr_req_q <= ctl_wr_req_d;
      ctl_rd_req_q <= ctl_rd_req_d;
      wdog_q       <= wdog_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  assign bus.p0_done    = done_q[0];
  assign bus.p1_done    = done_q[1];
  assign bus.p0_err     = err_q[0];
  assign bus.p1_err     = err_q[1];
  assign bus.p0_rdata   = rdata_q[0];
  assign bus.p1_rdata   = rdata_q[1];
  assign bus.ctl_wr_req = ctl_wr_req_q;
  assign bus.ctl_rd_req = ctl_rd_req_q;
  assign bus.ctl_addr   = ctl_addr_q;
  assign bus.ctl_wdata  = ctl_wdata_q;
  assign bus.grant_port = grant_port_q;
  assign bus.arb_state  = state_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
//   Self-checking bench for sdram_arbiter: hand sequences for init gating,
//   init_done falling mid-command and asynchronous reset; a vector table for
//   single commands, acks, timeouts and contention; and a randomized phase
//   checked against a transaction-level model of the arbitration rules.
module tb_sdram_arbiter;
  localparam int ADDR_W  = 24;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 16;

  logic clk_100m = 1'b0;
  logic rst_n    = 1'b0;
  always #5 clk_100m = ~clk_100m;

  sdram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_100m (clk_100m),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // The controller must never see both requests at once.
  always @(negedge clk_100m) begin
    if (rst_n) check("ctl_req_exclusive", 32'(bus.ctl_wr_req & bus.ctl_rd_req), 32'd0);
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_100m);
    #1;
  endtask

  logic              cmd_rw    [2];
  logic [ADDR_W-1:0] cmd_addr  [2];
  logic [DATA_W-1:0] cmd_wdata [2];

  task automatic drive_ports(input logic [1:0] mask);
    bus.p0_req   = mask[0];
    bus.p0_rw_n  = cmd_rw[0];
    bus.p0_addr  = cmd_addr[0];
    bus.p0_wdata = cmd_wdata[0];
    bus.p1_req   = mask[1];
    bus.p1_rw_n  = cmd_rw[1];
    bus.p1_addr  = cmd_addr[1];
    bus.p1_wdata = cmd_wdata[1];
  endtask

  // After the grant the command fields are don't-care; change them so a
  // design that fails to latch them is caught.
  task automatic scramble(input int p);
    if (p == 0) begin
      bus.p0_addr  = ADDR_W'($urandom);
      bus.p0_wdata = DATA_W'($urandom);
      bus.p0_rw_n  = 1'($urandom_range(0, 1));
    end else begin
      bus.p1_addr  = ADDR_W'($urandom);
      bus.p1_wdata = DATA_W'($urandom);
      bus.p1_rw_n  = 1'($urandom_range(0, 1));
    end
  endtask

  // One command from grant to completion. Call when the next edge sees
  // S_IDLE; returns one cycle after the done/err cycle. lat=0 means the
  // controller never acks.
  task automatic txn(input logic [1:0] mask, input int exp_port, input int lat,
                     input bit wrong, input logic [DATA_W-1:0] ack_data,
                     input bit exp_done, input bit exp_err,
                     input logic [DATA_W-1:0] exp_r0, input logic [DATA_W-1:0] exp_r1);
    int   n;
    bit   granted;
    bit   early;
    logic rw;
    drive_ports(mask);
    granted = 1'b0;
    for (int i = 0; i < 4 && !granted; i++) begin
      tick();
      granted = bus.ctl_wr_req | bus.ctl_rd_req;
    end
    check("grant_seen", 32'(granted), 32'd1);
    if (!granted) begin
      drive_ports(2'b00);
      tick();
      tick();
      return;
    end
    rw = cmd_rw[exp_port];
    check("grant_port", 32'(bus.grant_port), 32'(exp_port));
    check("arb_state_issue", 32'(bus.arb_state), 32'd1);
    check("ctl_wr_req", 32'(bus.ctl_wr_req), 32'(rw));
    check("ctl_rd_req", 32'(bus.ctl_rd_req), 32'(!rw));
    check("ctl_addr", 32'(bus.ctl_addr), 32'(cmd_addr[exp_port]));
    if (rw) check("ctl_wdata", 32'(bus.ctl_wdata), 32'(cmd_wdata[exp_port]));
    scramble(exp_port);
    n = (lat == 0) ? TIMEOUT : lat;
    early = 1'b0;
    for (int i = 1; i <= n; i++) begin
      if (i == n && lat != 0) begin
        if (rw) bus.ctl_wr_ack = 1'b1;
        else begin
          bus.ctl_rd_ack = 1'b1;
          bus.ctl_rdata  = ack_data;
        end
      end else if (wrong && i == 1) begin
        if (rw) begin
          bus.ctl_rd_ack = 1'b1;
          bus.ctl_rdata  = ~ack_data;
        end else bus.ctl_wr_ack = 1'b1;
      end
      tick();
      bus.ctl_wr_ack = 1'b0;
      bus.ctl_rd_ack = 1'b0;
      bus.ctl_rdata  = DATA_W'($urandom);
      if (i < n) begin
        early |= bus.p0_done | bus.p1_done | bus.p0_err | bus.p1_err;
        early |= !(bus.ctl_wr_req | bus.ctl_rd_req);
      end
    end
    check("no_early_end", 32'(early), 32'd0);
    check("done", 32'({bus.p1_done, bus.p0_done}), exp_done ? 32'(1 << exp_port) : 32'd0);
    check("err", 32'({bus.p1_err, bus.p0_err}), exp_err ? 32'(1 << exp_port) : 32'd0);
    check("ctl_req_dropped", 32'({bus.ctl_wr_req, bus.ctl_rd_req}), 32'd0);
    check("p0_rdata", 32'(bus.p0_rdata), 32'(exp_r0));
    check("p1_rdata", 32'(bus.p1_rdata), 32'(exp_r1));
    check("arb_state_recover", 32'(bus.arb_state), 32'd2);
    $display("txn port=%0d %s addr=%h lat=%0d done=%0b err=%0b rdata0=%h rdata1=%h",
             exp_port, rw ? "WR" : "RD", cmd_addr[exp_port], lat,
             exp_done, exp_err, bus.p0_rdata, bus.p1_rdata);
    if (exp_port == 0) bus.p0_req = 1'b0;
    else bus.p1_req = 1'b0;
    tick();
    check("pulse_one_cycle", 32'({bus.p1_done, bus.p0_done, bus.p1_err, bus.p0_err}), 32'd0);
    check("arb_state_idle", 32'(bus.arb_state), 32'd0);
  endtask

  typedef struct {
    logic [1:0]        mask;
    logic              rw;
    logic [ADDR_W-1:0] a0;
    logic [ADDR_W-1:0] a1;
    logic [DATA_W-1:0] wd;
    int                lat;
    bit                wrong;
    logic [DATA_W-1:0] ack;
    int                port;
    bit                done;
    bit                err;
    logic [DATA_W-1:0] r0;
    logic [DATA_W-1:0] r1;
  } vec_t;

  vec_t vt [12];

  // Transaction-level reference state.
  int                m_last;
  logic [DATA_W-1:0] m_rdata [2];
  bit                pending [2];

  initial begin
    bit seen;
    int exp_p;
    int lat;
    bit wr;
    logic [DATA_W-1:0] ad;

    // mask rw a0 a1 wdata lat wrong ack | port done err r0 r1
    vt[0]  = '{2'b10, 1'b1, 24'h000000, 24'h000123, 16'hBEEF, 8,  1'b0, 16'h0000, 1, 1'b1, 1'b0, 16'h1111, 16'h0000};
    vt[1]  = '{2'b01, 1'b0, 24'h000456, 24'h000000, 16'h0000, 3,  1'b0, 16'h5A5A, 0, 1'b1, 1'b0, 16'h5A5A, 16'h0000};
    vt[2]  = '{2'b01, 1'b1, 24'h000789, 24'h000000, 16'h1357, 2,  1'b1, 16'h2468, 0, 1'b1, 1'b0, 16'h5A5A, 16'h0000};
    vt[3]  = '{2'b10, 1'b0, 24'h000000, 24'h00ABCD, 16'h0000, 0,  1'b0, 16'h9999, 1, 1'b0, 1'b1, 16'h5A5A, 16'h0000};
    vt[4]  = '{2'b10, 1'b0, 24'h000000, 24'h00BCDE, 16'h0000, 16, 1'b0, 16'hC0DE, 1, 1'b1, 1'b0, 16'h5A5A, 16'hC0DE};
    vt[5]  = '{2'b10, 1'b0, 24'h000000, 24'h00CDEF, 16'h0000, 4,  1'b1, 16'h0F0F, 1, 1'b1, 1'b0, 16'h5A5A, 16'h0F0F};
    vt[6]  = '{2'b11, 1'b0, 24'h100000, 24'h200000, 16'h0000, 1,  1'b0, 16'hA000, 0, 1'b1, 1'b0, 16'hA000, 16'h0F0F};
    vt[7]  = '{2'b11, 1'b1, 24'h100001, 24'h200001, 16'h7001, 2,  1'b0, 16'hA001, 1, 1'b1, 1'b0, 16'hA000, 16'h0F0F};
    vt[8]  = '{2'b11, 1'b0, 24'h100002, 24'h200002, 16'h0000, 3,  1'b0, 16'hA002, 0, 1'b1, 1'b0, 16'hA002, 16'h0F0F};
    vt[9]  = '{2'b11, 1'b0, 24'h100003, 24'h200003, 16'h0000, 1,  1'b0, 16'hA003, 1, 1'b1, 1'b0, 16'hA002, 16'hA003};
    vt[10] = '{2'b11, 1'b1, 24'h100004, 24'h200004, 16'h7004, 5,  1'b0, 16'hA004, 0, 1'b1, 1'b0, 16'hA002, 16'hA003};
    vt[11] = '{2'b11, 1'b0, 24'h100005, 24'h200005, 16'h0000, 2,  1'b0, 16'hA005, 1, 1'b1, 1'b0, 16'hA002, 16'hA005};

    for (int p = 0; p < 2; p++) begin
      cmd_rw[p]    = 1'b0;
      cmd_addr[p]  = '0;
      cmd_wdata[p] = '0;
    end
    drive_ports(2'b00);
    bus.sdram_init_done = 1'b0;
    bus.ctl_wr_ack      = 1'b0;
    bus.ctl_rd_ack      = 1'b0;
    bus.ctl_rdata       = '0;

    // Reset values.
    tick();
    tick();
    check("rst_state", 32'(bus.arb_state), 32'd0);
    check("rst_outputs", 32'({bus.ctl_wr_req, bus.ctl_rd_req, bus.grant_port,
                              bus.p0_done, bus.p1_done, bus.p0_err, bus.p1_err}), 32'd0);
    check("rst_rdata", 32'({bus.p0_rdata, bus.p1_rdata}), 32'd0);
    #4 rst_n = 1'b1;
    tick();

    // Init gating: p0 read held while init incomplete.
    cmd_rw[0]   = 1'b0;
    cmd_addr[0] = 24'h0ABCDE;
    drive_ports(2'b01);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      seen |= bus.ctl_rd_req | bus.ctl_wr_req;
    end
    check("init_gating", 32'(seen), 32'd0);
    bus.sdram_init_done = 1'b1;
    tick();
    check("init_grant_rd_req", 32'(bus.ctl_rd_req), 32'd1);
    check("init_grant_addr", 32'(bus.ctl_addr), 32'h0ABCDE);
    tick();
    bus.ctl_rd_ack = 1'b1;
    bus.ctl_rdata  = 16'h1111;
    tick();
    bus.ctl_rd_ack = 1'b0;
    check("init_done_pulse", 32'(bus.p0_done), 32'd1);
    check("init_rdata", 32'(bus.p0_rdata), 32'h1111);
    $display("txn port=0 RD addr=0abcde init-gated done=%0b rdata0=%h", bus.p0_done, bus.p0_rdata);
    bus.p0_req = 1'b0;
    tick();

    // init_done falling mid-command: command finishes, new grants wait.
    cmd_rw[1]    = 1'b1;
    cmd_addr[1]  = 24'h00F00D;
    cmd_wdata[1] = 16'h4321;
    drive_ports(2'b10);
    tick();
    check("initfall_grant", 32'(bus.ctl_wr_req), 32'd1);
    bus.sdram_init_done = 1'b0;
    tick();
    bus.ctl_wr_ack = 1'b1;
    tick();
    bus.ctl_wr_ack = 1'b0;
    check("initfall_done", 32'(bus.p1_done), 32'd1);
    bus.p1_req = 1'b0;
    tick();
    bus.p1_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen |= bus.ctl_wr_req | bus.ctl_rd_req;
    end
    check("initfall_blocked", 32'(seen), 32'd0);
    bus.sdram_init_done = 1'b1;
    tick();
    check("initfall_regrant", 32'(bus.ctl_wr_req), 32'd1);
    bus.ctl_wr_ack = 1'b1;
    tick();
    bus.ctl_wr_ack = 1'b0;
    check("initfall_done2", 32'(bus.p1_done), 32'd1);
    $display("txn port=1 WR addr=00f00d init-blocked done=%0b", bus.p1_done);
    bus.p1_req = 1'b0;
    tick();

    // Vector table.
    for (int i = 0; i < 12; i++) begin
      cmd_rw[0]    = vt[i].rw;
      cmd_rw[1]    = vt[i].rw;
      cmd_addr[0]  = vt[i].a0;
      cmd_addr[1]  = vt[i].a1;
      cmd_wdata[0] = vt[i].wd;
      cmd_wdata[1] = vt[i].wd;
      txn(vt[i].mask, vt[i].port, vt[i].lat, vt[i].wrong, vt[i].ack,
          vt[i].done, vt[i].err, vt[i].r0, vt[i].r1);
    end

    // Randomized phase against the transaction model.
    m_last     = vt[11].port;
    m_rdata[0] = vt[11].r0;
    m_rdata[1] = vt[11].r1;
    pending[0] = 1'b0;
    pending[1] = 1'b0;
    for (int t = 0; t < 40; t++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pending[p] && $urandom_range(0, 1) == 1) begin
          pending[p]   = 1'b1;
          cmd_rw[p]    = 1'($urandom_range(0, 1));
          cmd_addr[p]  = ADDR_W'($urandom);
          cmd_wdata[p] = DATA_W'($urandom);
        end
      end
      if (!pending[0] && !pending[1]) begin
        exp_p = $urandom_range(0, 1);
        pending[exp_p]   = 1'b1;
        cmd_rw[exp_p]    = 1'($urandom_range(0, 1));
        cmd_addr[exp_p]  = ADDR_W'($urandom);
        cmd_wdata[exp_p] = DATA_W'($urandom);
      end
      if (pending[0] && pending[1]) exp_p = 1 - m_last;
      else exp_p = pending[0] ? 0 : 1;
      lat = $urandom_range(0, 7);
      wr  = 1'($urandom_range(0, 1));
      ad  = DATA_W'($urandom);
      if (lat != 0 && !cmd_rw[exp_p]) m_rdata[exp_p] = ad;
      txn({pending[1], pending[0]}, exp_p, lat, wr, ad, lat != 0, lat == 0,
          m_rdata[0], m_rdata[1]);
      pending[exp_p] = 1'b0;
      m_last = exp_p;
    end
    drive_ports(2'b00);
    tick();

    // Asynchronous reset in the middle of a p1 read.
    cmd_rw[1]   = 1'b0;
    cmd_addr[1] = 24'h0C0FFE;
    drive_ports(2'b10);
    tick();
    check("arst_granted", 32'(bus.ctl_rd_req), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_rd_req", 32'(bus.ctl_rd_req), 32'd0);
    check("arst_state", 32'(bus.arb_state), 32'd0);
    check("arst_outputs", 32'({bus.ctl_wr_req, bus.grant_port, bus.p0_done,
                               bus.p1_done, bus.p0_err, bus.p1_err}), 32'd0);
    check("arst_rdata", 32'({bus.p0_rdata, bus.p1_rdata}), 32'd0);
    cmd_rw[0]   = 1'b0;
    cmd_addr[0] = 24'h0D0D0D;
    drive_ports(2'b11);
    @(negedge clk_100m);
    rst_n = 1'b1;
    tick();
    check("arst_first_grant", 32'(bus.grant_port), 32'd0);
    check("arst_first_addr", 32'(bus.ctl_addr), 32'h0D0D0D);
    $display("txn port=%0d RD addr=%h after-reset", bus.grant_port, bus.ctl_addr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
